mul8_seq_ctrl: RTL and testbench
================================

# mul8_seq_ctrl

Sequencing controller that computes an unsigned 8x8 -> 16-bit product by time-sharing a single 4x4 add-tree multiplier across four nibble partial products. It wraps the shared 4x4 multiplier, or an internal instance of it, with a valid/ready operand port and a valid/ready result port. It sits between the tile I/O pins and the arithmetic core. It owns operand capture, partial-product scheduling, accumulation and result hand-off.

## Interface
- Parameters: none. Widths are fixed at 8-bit operands, 4x4 partial products and a 16-bit result.
- `clk` input 1: single clock; everything samples on the rising edge.
- `rst_n` input 1: synchronous, active-high reset. A high level sampled at a rising edge resets the block.
- `in_valid` input 1: operand pair present.
- `in_ready` output 1: controller can accept an operand pair.
- `in_a` input 8: multiplicand, unsigned.
- `in_b` input 8: multiplier, unsigned.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts the result.
- `result` output 16: product `in_a*in_b`.
- `busy` output 1: state is not IDLE.
- `op_count` output 8: number of completed result hand-offs; wraps modulo 256.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch A=`in_a` and B=`in_b`, clear the 16-bit accumulator, select the first step, go to CALC.
- Step order and contribution of each step:
  - s0: A[3:0]*B[3:0], shifted left by 0.
  - s1: A[3:0]*B[7:4], shifted left by 4.
  - s2: A[7:4]*B[3:0], shifted left by 4.
  - s3: A[7:4]*B[7:4], shifted left by 8.
- CALC:
  - The 4x4 multiplier inputs are muxed from the latched nibbles of the current step.
  - acc <= acc + (pp << shift) each cycle, as a 16-bit add. The true product is at most 0xFE01, so the add never overflows.
  - After the last step, go to DONE.
- DONE:
  - `out_valid`=1 and `result`=acc, both held stable until `out_ready`.
  - On `out_valid & out_ready`: go to IDLE and increment `op_count`.
  - `in_ready`=0 in DONE. A new operand is never accepted in the same cycle as a hand-off.
- `in_a`/`in_b` changes after acceptance have no effect.
- `result` holds its last value outside DONE. It is don't-care for checking when `out_valid`=0.
- `busy` = (state != IDLE).

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `result`=0x0000, `op_count`=0x00, acc=0, step=s0.
- Reset mid-operation (CALC or DONE): the next cycle is IDLE with the reset values above. The in-flight result is discarded and `op_count` is not incremented.
- Reset has priority over every handshake sampled on the same edge.
- Default latency: the operand is accepted at edge E0. CALC covers edges E1..E4. `out_valid`=1 in the cycle after E4, i.e. 4 cycles after acceptance.
- Earliest next accept: edge E6 when `out_ready` is held at 1. Peak throughput is 1 op per 6 cycles.
- Backpressure: `out_valid`, `result` and `busy` are held indefinitely while `out_ready`=0.
- `out_ready`=1 outside DONE has no effect.
- `in_valid`=1 while `in_ready`=0 is ignored. It is not queued.

## Configuration
- `MUL8_SEQ_SKIP_EN` defined:
  - At acceptance, a 4-bit step mask is computed. A step is enabled iff both of its nibbles are nonzero.
  - CALC visits only the enabled steps, in s0..s3 order, one cycle each.
  - If no step is enabled (the product is 0), CALC takes exactly one cycle and adds 0.
  - Latency = max(1, number of enabled steps) cycles before `out_valid`.
- `MUL8_SEQ_SKIP_EN` not defined: all four steps always run, and latency is fixed at 4.
- `result` is bit-identical in both builds.

## Test plan
- Basic: accept `in_a`=0x12, `in_b`=0x34 -> `out_valid` 4 cycles later, `result`=0x03A8, `op_count`=1 after the hand-off.
- Max operands: 0xFF*0xFF -> `result`=0xFE01. Then back-to-back ops with `out_ready`=1 -> accepts exactly 6 cycles apart, and `in_ready`=0 throughout CALC/DONE.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` -> `result` stable, `in_ready`=0, a new `in_valid` is ignored. Then release -> IDLE next cycle, count +1.
- Reset mid-CALC: assert `rst_n` at the 2nd CALC cycle -> next cycle `busy`=0, `out_valid`=0, `in_ready`=1, `op_count` unchanged. A following 0x03*0x05 op -> 0x000F.
- Skip build: 0x05*0x30 -> `result`=0x00F0 with latency 1. 0x00*0x77 -> 0x0000 with latency 1. 0x11*0x11 -> 0x0121 with latency 4.
- Non-skip build: 0x00*0x77 -> 0x0000 with latency 4. 256 completed ops -> `op_count` wraps to 0x00.

Source files
------------

// File: rtl/mul8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul8_seq_ctrl
// Purpose  : Unsigned 8x8 -> 16-bit multiplier built from one shared 4x4
//            add-tree multiplier. The four nibble partial products are
//            scheduled over consecutive cycles and accumulated, then the
//            product is handed off on a valid/ready result port.
// Ports    : clk        - rising-edge clock
//            rst_n      - synchronous reset, ACTIVE-HIGH despite the name
//            in_valid   - operand pair present
//            in_ready   - controller can accept an operand pair (IDLE)
//            in_a/in_b  - 8-bit unsigned operands
//            out_valid  - result present (DONE)
//            out_ready  - consumer accepts the result
//            result     - 16-bit product, held outside DONE
//            busy       - controller is not IDLE
//            op_count   - completed hand-offs, modulo 256
// Build    : define MUL8_SEQ_SKIP_EN to skip partial-product steps whose
//            nibble pair contains a zero nibble (data-dependent latency).
// Revision : 1.0 - initial release
// ============================================================================
module mul8_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy,
    output logic [7:0]  op_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [1:0]  r_step;
    logic [15:0] r_result;
    logic [7:0]  r_op_count;

    logic [1:0]  w_state_nxt;
    logic [7:0]  w_a_nxt;
    logic [7:0]  w_b_nxt;
    logic [15:0] w_acc_nxt;
    logic [1:0]  w_step_nxt;
    logic [15:0] w_result_nxt;
    logic [7:0]  w_op_count_nxt;

    logic [3:0]  w_na;
    logic [3:0]  w_nb;
    logic [7:0]  w_pp;
    logic [15:0] w_pp_shifted;
    logic [15:0] w_sum;
    logic [1:0]  w_first_step;
    logic [1:0]  w_next_step;
    logic        w_last_step;

    // Nibble mux for the current step: s0 lo*lo, s1 lo*hi, s2 hi*lo, s3 hi*hi.
    always_comb begin
        w_na = r_a[3:0];
        w_nb = r_b[3:0];
        case (r_step)
            2'd0: begin w_na = r_a[3:0]; w_nb = r_b[3:0]; end
            2'd1: begin w_na = r_a[3:0]; w_nb = r_b[7:4]; end
            2'd2: begin w_na = r_a[7:4]; w_nb = r_b[3:0]; end
            default: begin w_na = r_a[7:4]; w_nb = r_b[7:4]; end
        endcase
    end

    // Shared 4x4 add-tree multiplier: one gated, shifted row per multiplier bit.
    // 15*15 = 225 fits in 8 bits, so the tree sum cannot overflow.
    assign w_pp = {4'h0, w_na & {4{w_nb[0]}}}
                + {3'h0, w_na & {4{w_nb[1]}}, 1'b0}
                + {2'h0, w_na & {4{w_nb[2]}}, 2'b0}
                + {1'b0, w_na & {4{w_nb[3]}}, 3'b0};

    always_comb begin
        w_pp_shifted = {8'h00, w_pp};
        case (r_step)
            2'd0:    w_pp_shifted = {8'h00, w_pp};
            2'd1,
            2'd2:    w_pp_shifted = {4'h0, w_pp, 4'h0};
            default: w_pp_shifted = {w_pp, 8'h00};
        endcase
    end

    // Full product never exceeds 0xFE01, so this 16-bit add cannot wrap.
    assign w_sum = r_acc + w_pp_shifted;

`ifdef MUL8_SEQ_SKIP_EN
    logic [3:0] r_mask;
    logic [3:0] w_mask_nxt;
    logic [3:0] w_mask_in;
    logic [3:0] w_mask_rem;

    function automatic logic [1:0] first_set(input logic [3:0] m);
        if (m[0])      first_set = 2'd0;
        else if (m[1]) first_set = 2'd1;
        else if (m[2]) first_set = 2'd2;
        else if (m[3]) first_set = 2'd3;
        else           first_set = 2'd0;
    endfunction

    // A step contributes only if both of its nibbles are nonzero.
    assign w_mask_in = {(in_a[7:4] != 4'h0) && (in_b[7:4] != 4'h0),
                        (in_a[7:4] != 4'h0) && (in_b[3:0] != 4'h0),
                        (in_a[3:0] != 4'h0) && (in_b[7:4] != 4'h0),
                        (in_a[3:0] != 4'h0) && (in_b[3:0] != 4'h0)};

    // An empty mask still runs s0 once; its partial product is zero anyway.
    assign w_first_step = first_set(w_mask_in);
    assign w_mask_rem   = r_mask & ~(4'b0001 << r_step);
    assign w_last_step  = (w_mask_rem == 4'h0);
    assign w_next_step  = first_set(w_mask_rem);

    always_comb begin
        w_mask_nxt = r_mask;
        if ((r_state == S_IDLE) && in_valid) begin
            w_mask_nxt = w_mask_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_mask <= 4'h0;
        end else begin
            r_mask <= w_mask_nxt;
        end
    end
`else
    assign w_first_step = 2'd0;
    assign w_last_step  = (r_step == 2'd3);
    assign w_next_step  = r_step + 2'd1;
`endif

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt    = r_state;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_acc_nxt      = r_acc;
        w_step_nxt     = r_step;
        w_result_nxt   = r_result;
        w_op_count_nxt = r_op_count;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_a_nxt     = in_a;
                    w_b_nxt     = in_b;
                    w_acc_nxt   = 16'h0000;
                    w_step_nxt  = w_first_step;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_acc_nxt  = w_sum;
                w_step_nxt = w_next_step;
                if (w_last_step) begin
                    // Separate result register keeps the product visible
                    // after the accumulator is cleared by the next accept.
                    w_result_nxt = w_sum;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_op_count_nxt = r_op_count + 8'd1;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= 8'h00;
            r_b        <= 8'h00;
            r_acc      <= 16'h0000;
            r_step     <= 2'd0;
            r_result   <= 16'h0000;
            r_op_count <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_acc      <= w_acc_nxt;
            r_step     <= w_step_nxt;
            r_result   <= w_result_nxt;
            r_op_count <= w_op_count_nxt;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_mul8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul8_seq_ctrl
// Purpose  : Self-checking bench for mul8_seq_ctrl. Directed corner cases
//            followed by randomized operands and back-pressure, checked
//            against an arithmetic reference (product, latency, hand-off
//            count). Define MUL8_SEQ_SKIP_EN to match a skip-enabled build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul8_seq_ctrl;

`ifdef MUL8_SEQ_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        busy;
    logic [7:0]  op_count;

    int          n_checks;
    int          n_fail;
    int          cyc;
    int          last_accept;
    bit          chain;
    logic [7:0]  exp_count;
    int          total_done;

    mul8_seq_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference latency: number of nibble products with both nibbles nonzero
    // (at least one cycle) when skipping, otherwise always four.
    function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        if (a[3:0] != 0 && b[3:0] != 0) n++;
        if (a[3:0] != 0 && b[7:4] != 0) n++;
        if (a[7:4] != 0 && b[3:0] != 0) n++;
        if (a[7:4] != 0 && b[7:4] != 0) n++;
        if (n == 0) n = 1;
        return SKIP ? n : 4;
    endfunction

    // Entered and left at a falling edge. stall=0 keeps out_ready high so
    // consecutive calls run back to back.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall);
        int          lat;
        logic [15:0] held;
        logic [15:0] prod;
        prod      = 16'(a) * 16'(b);
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1;
        if (chain && stall == 0) chk("accept_gap", cyc - last_accept, 6);
        last_accept = cyc;
        in_valid = $urandom_range(0, 1);
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            chk("in_ready_calc", in_ready, 0);
            chk("busy_calc", busy, 1);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", lat, exp_lat(a, b));
        chk("result", result, prod);
        chk("in_ready_done", in_ready, 0);
        held = result;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_result", result, held);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_busy", busy, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        exp_count++;
        total_done++;
        chk("post_valid", out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_in_ready", in_ready, 1);
        chk("op_count", op_count, exp_count);
        if (total_done == 256) chk("op_count_wrap", op_count, 8'h00);
        chain = (stall == 0);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        n_checks    = 0;
        n_fail      = 0;
        exp_count   = 8'h00;
        total_done  = 0;
        chain       = 1'b0;
        last_accept = 0;
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        in_a        = 8'h00;
        in_b        = 8'h00;
        out_ready   = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 16'h0000);
        chk("rst_op_count", op_count, 8'h00);

        // Reset on the second CALC edge discards the operation.
        in_a = 8'hC7; in_b = 8'h9B; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_count = 8'h00;
        @(negedge clk);
        chk("rcalc_busy", busy, 0);
        chk("rcalc_out_valid", out_valid, 0);
        chk("rcalc_in_ready", in_ready, 1);
        chk("rcalc_op_count", op_count, exp_count);
        repeat (6) @(negedge clk);
        chk("rcalc_stays_idle", out_valid, 0);

        // Reset wins over a hand-off sampled on the same edge.
        in_a = 8'h21; in_b = 8'h43; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("rdone_reached", out_valid, 1);
        out_ready = 1'b1;
        rst_n     = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_count = 8'h00;
        @(negedge clk);
        chk("rdone_out_valid", out_valid, 0);
        chk("rdone_busy", busy, 0);
        chk("rdone_op_count", op_count, exp_count);
        chain = 1'b0;

        // Directed cases.
        run_op(8'h12, 8'h34, 0);
        run_op(8'h03, 8'h05, 0);
        run_op(8'hFF, 8'hFF, 0);
        run_op(8'hFF, 8'hFF, 0);
        run_op(8'h00, 8'h77, 0);
        run_op(8'h05, 8'h30, 0);
        run_op(8'h11, 8'h11, 0);
        run_op(8'hA5, 8'h5A, 10);
        run_op(8'h80, 8'h01, 1);

        // Randomized operands, nibble zeros biased in, random back-pressure.
        while (total_done < 270) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ra[3:0] = 4'h0;
            if ($urandom_range(0, 3) == 0) ra[7:4] = 4'h0;
            if ($urandom_range(0, 3) == 0) rb[3:0] = 4'h0;
            if ($urandom_range(0, 3) == 0) rb[7:4] = 4'h0;
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                chain = 1'b0;
            end
            run_op(ra, rb, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
